// File: rtl/sixteen_segment_decoder_if.sv
// Segment read-back bus: raw pins in, decoded character out over valid/ready.
// Optional macro SEGMENT_DECIMAL_POINT_EN adds the decimal-point pin and flag.
interface sixteen_segment_decoder_if;
   logic [15:0] seg_in;
   logic [6:0]  char_out;
   logic        char_unknown;
   logic        char_valid;
   logic        char_ready;
   logic [15:0] settled_pattern;
`ifdef SEGMENT_DECIMAL_POINT_EN
   logic        dp_in;
   logic        char_dp;
`endif

`ifdef SEGMENT_DECIMAL_POINT_EN
   modport master (
      output seg_in, char_ready, dp_in,
      input  char_out, char_unknown, char_valid, settled_pattern, char_dp
   );
   modport slave (
      input  seg_in, char_ready, dp_in,
      output char_out, char_unknown, char_valid, settled_pattern, char_dp
   );
`else
   modport master (
      output seg_in, char_ready,
      input  char_out, char_unknown, char_valid, settled_pattern
   );
   modport slave (
      input  seg_in, char_ready,
      output char_out, char_unknown, char_valid, settled_pattern
   );
`endif
endinterface

// File: rtl/sixteen_segment_decoder.sv
// Recovers the ASCII character shown on a 16-segment display from its pins.
// Optional macro SEGMENT_DECIMAL_POINT_EN widens the settled pattern by the dp bit.
module sixteen_segment_decoder #(
   parameter int STABLE_CYCLES = 16,
   parameter int ACTIVE_LOW    = 1
) (
   input  logic                      CLK,
   input  logic                      reset,
   sixteen_segment_decoder_if.slave  io_bus
);

`ifdef SEGMENT_DECIMAL_POINT_EN
   localparam int W = 17;
`else
   localparam int W = 16;
`endif

   localparam logic [15:0]  CNT_MAX = 16'(STABLE_CYCLES - 1);
   localparam logic [15:0]  CNT_PRE = 16'(STABLE_CYCLES - 2);
   localparam logic [W-1:0] L_RST   = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_PRESENT} state_t;

   // Returns {unknown, ascii} for a logical (1 = lit) segment pattern.
   function automatic logic [7:0] decode(input logic [15:0] pat);
      logic [7:0] res;
      res = {1'b1, 7'h3F};
      case (pat)
         16'h0000: res = {1'b0, 7'h20};
         16'hFF00: res = {1'b0, 7'h30};
         16'h3000: res = {1'b0, 7'h31};
         16'hEE18: res = {1'b0, 7'h32};
         16'hF000: res = {1'b0, 7'h37};
         16'hFF18: res = {1'b0, 7'h38};
         16'h0018: res = {1'b0, 7'h2D};
         16'h3318: res = {1'b0, 7'h48};
         16'hCC42: res = {1'b0, 7'h49};
         default:  res = {1'b1, 7'h3F};
      endcase
      return res;
   endfunction

   logic [W-1:0] w_raw;
   logic [W-1:0] w_l;
   logic         w_same;
   logic         w_settle;
   logic         w_new;
   logic         w_load;
   logic [W-1:0] w_load_pat;
   logic         w_clr_pend;
   state_t       w_state_d;

   logic [W-1:0] r_sync1;
   logic [W-1:0] r_sync2;
   logic [W-1:0] r_prev;
   logic [15:0]  r_cnt;
   logic [W-1:0] r_settled;
   logic         r_pend;
   logic [W-1:0] r_pend_pat;
   logic [6:0]   r_char;
   logic         r_unk;
   state_t       r_state;

`ifdef SEGMENT_DECIMAL_POINT_EN
   logic         r_dp;
   assign w_raw          = {io_bus.dp_in, io_bus.seg_in};
   assign io_bus.char_dp = r_dp;
`else
   assign w_raw          = io_bus.seg_in;
`endif

   assign w_l      = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
   assign w_same   = (w_l == r_prev);
   assign w_settle = w_same && (r_cnt == CNT_PRE);
   assign w_new    = w_settle && (w_l != r_settled);

   // Input synchroniser and stability counter
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= L_RST;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_prev  <= w_l;
         if (!w_same)
            r_cnt <= '0;
         else if (r_cnt != CNT_MAX)
            r_cnt <= r_cnt + 16'd1;
      end
   end

   // A fresh settle arriving on the handshake cycle wins over the stored pending one.
   always_comb begin
      w_state_d  = r_state;
      w_load     = 1'b0;
      w_load_pat = w_l;
      w_clr_pend = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_new) begin
               w_state_d = S_LOOKUP;
               w_load    = 1'b1;
            end
         end
         S_LOOKUP: w_state_d = S_PRESENT;
         S_PRESENT: begin
            if (io_bus.char_ready) begin
               w_clr_pend = 1'b1;
               if (w_new) begin
                  w_state_d = S_LOOKUP;
                  w_load    = 1'b1;
               end else if (r_pend) begin
                  w_state_d  = S_LOOKUP;
                  w_load     = 1'b1;
                  w_load_pat = r_pend_pat;
               end else begin
                  w_state_d = S_IDLE;
               end
            end
         end
         default: w_state_d = S_IDLE;
      endcase
   end

   // Control state, settled pattern and decoded outputs
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_settled <= '0;
         r_pend    <= 1'b0;
         r_char    <= 7'h20;
         r_unk     <= 1'b0;
`ifdef SEGMENT_DECIMAL_POINT_EN
         r_dp      <= 1'b0;
`endif
      end else begin
         r_state <= w_state_d;
         if (w_load)
            r_settled <= w_load_pat;
         if (w_clr_pend)
            r_pend <= 1'b0;
         else if (w_new && (r_state != S_IDLE))
            r_pend <= 1'b1;
         if (r_state == S_LOOKUP) begin
            {r_unk, r_char} <= decode(r_settled[15:0]);
`ifdef SEGMENT_DECIMAL_POINT_EN
            r_dp <= r_settled[16];
`endif
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (w_new && (r_state != S_IDLE))
         r_pend_pat <= w_l;
   end

   assign io_bus.char_out        = r_char;
   assign io_bus.char_unknown    = r_unk;
   assign io_bus.char_valid      = (r_state == S_PRESENT);
   assign io_bus.settled_pattern = r_settled[15:0];

endmodule

// File: tb/tb_sixteen_segment_decoder.sv
// Randomised and directed bench for sixteen_segment_decoder with a table-driven reference.
module tb_sixteen_segment_decoder;
   localparam int S = 16;

   logic CLK = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_fail = 0;

   sixteen_segment_decoder_if bus ();

   sixteen_segment_decoder #(.STABLE_CYCLES(S), .ACTIVE_LOW(1)) dut (
      .CLK    (CLK),
      .reset  (reset),
      .io_bus (bus)
   );

   always #5 CLK = ~CLK;

   logic [15:0] tbl_pat [9] = '{16'h0000, 16'hFF00, 16'h3000, 16'hEE18, 16'hF000,
                                16'hFF18, 16'h0018, 16'h3318, 16'hCC42};
   logic [6:0]  tbl_chr [9] = '{7'h20, 7'h30, 7'h31, 7'h32, 7'h37, 7'h38, 7'h2D, 7'h48, 7'h49};

   function automatic logic [7:0] ref_decode(input logic [15:0] p);
      logic [7:0] r;
      r = {1'b1, 7'h3F};
      for (int i = 0; i < 9; i++)
         if (p == tbl_pat[i]) r = {1'b0, tbl_chr[i]};
      return r;
   endfunction

   // Handshake monitor: records {pattern, unknown, char} for every accepted character.
   bit           mon_en = 1'b0;
   logic [23:0]  mon_q[$];
   always @(negedge CLK)
      if (mon_en && bus.char_valid && bus.char_ready)
         mon_q.push_back({bus.settled_pattern, bus.char_unknown, bus.char_out});

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic wait_valid(input int max, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < max && !ok) begin
         step(1);
         n++;
         if (bus.char_valid) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      bit seen;
      reset = 1'b1;
      bus.seg_in = 16'hFFFF;
      bus.char_ready = 1'b0;
`ifdef SEGMENT_DECIMAL_POINT_EN
      bus.dp_in = 1'b1;
`endif
      step(3);
      n_cmp++; if (bus.char_out !== 7'h20) begin n_fail++; $display("FAIL rst_char got=%h want=20", bus.char_out); end
      n_cmp++; if (bus.char_unknown !== 1'b0) begin n_fail++; $display("FAIL rst_unk got=%b want=0", bus.char_unknown); end
      n_cmp++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b want=0", bus.char_valid); end
      n_cmp++; if (bus.settled_pattern !== 16'h0000) begin n_fail++; $display("FAIL rst_settled got=%h want=0000", bus.settled_pattern); end
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (bus.char_valid) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL blank_no_char got=%b want=0", seen); end
   endtask

   task automatic test_latency;
      int n; bit ok; bit seen;
      bus.char_ready = 1'b1;
      bus.seg_in = ~16'hFF00;
      step(1);
      wait_valid(40, n, ok);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL lat_timeout got=%b want=1", ok); end
      n_cmp++; if (n !== S + 2) begin n_fail++; $display("FAIL lat_cycles got=%0d want=%0d", n, S + 2); end
      n_cmp++; if (bus.char_out !== 7'h30) begin n_fail++; $display("FAIL lat_char got=%h want=30", bus.char_out); end
      n_cmp++; if (bus.char_unknown !== 1'b0) begin n_fail++; $display("FAIL lat_unk got=%b want=0", bus.char_unknown); end
      n_cmp++; if (bus.settled_pattern !== 16'hFF00) begin n_fail++; $display("FAIL lat_settled got=%h want=FF00", bus.settled_pattern); end
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         step(1);
         if (bus.char_valid) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL lat_single_pulse got=%b want=0", seen); end
   endtask

   task automatic test_hold;
      int n; bit ok; int bad;
      bus.char_ready = 1'b0;
      bus.seg_in = ~16'h3000;
      wait_valid(40, n, ok);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL hold_timeout got=%b want=1", ok); end
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (bus.char_valid !== 1'b1 || bus.char_out !== 7'h31) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL hold_stable got=%0d bad cycles want=0", bad); end
      bus.char_ready = 1'b1;
      step(1);
      n_cmp++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL hold_drop got=%b want=0", bus.char_valid); end
   endtask

   task automatic test_toggle;
      bit seen;
      bus.char_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         bus.seg_in = (i % 2 == 0) ? ~16'hFF00 : ~16'h3000;
         for (int j = 0; j < 8; j++) begin
            step(1);
            if (bus.char_valid) seen = 1'b1;
         end
      end
      n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL toggle_no_settle got=%b want=0", seen); end
   endtask

   task automatic test_back_to_back;
      int n; bit ok; bit seen;
      bus.char_ready = 1'b1;
      bus.seg_in = ~16'h3318;
      wait_valid(40, n, ok);
      n_cmp++; if (ok !== 1'b1 || bus.char_out !== 7'h48) begin n_fail++; $display("FAIL b2b_H got=%h ok=%b want=48", bus.char_out, ok); end
      step(2);
      bus.char_ready = 1'b0;
      bus.seg_in = ~16'h3000;
      wait_valid(40, n, ok);
      n_cmp++; if (ok !== 1'b1 || bus.char_out !== 7'h31) begin n_fail++; $display("FAIL b2b_one got=%h ok=%b want=31", bus.char_out, ok); end
      bus.seg_in = ~16'hEE18;
      step(20);
      bus.seg_in = ~16'hFF18;
      step(20);
      n_cmp++; if (bus.char_valid !== 1'b1 || bus.char_out !== 7'h31) begin n_fail++; $display("FAIL b2b_still_one got=%h v=%b want=31", bus.char_out, bus.char_valid); end
      bus.char_ready = 1'b1;
      step(1);
      wait_valid(10, n, ok);
      n_cmp++; if (ok !== 1'b1 || bus.char_out !== 7'h38) begin n_fail++; $display("FAIL b2b_latest got=%h ok=%b want=38", bus.char_out, ok); end
      n_cmp++; if (bus.settled_pattern !== 16'hFF18) begin n_fail++; $display("FAIL b2b_settled got=%h want=FF18", bus.settled_pattern); end
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (bus.char_valid) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL b2b_discard got=%b want=0", seen); end
   endtask

   task automatic test_unknown;
      int n; bit ok;
      bus.char_ready = 1'b1;
      bus.seg_in = ~16'h1234;
      wait_valid(40, n, ok);
      n_cmp++; if (ok !== 1'b1 || bus.char_out !== 7'h3F) begin n_fail++; $display("FAIL unk_char got=%h ok=%b want=3F", bus.char_out, ok); end
      n_cmp++; if (bus.char_unknown !== 1'b1) begin n_fail++; $display("FAIL unk_flag got=%b want=1", bus.char_unknown); end
      step(3);
   endtask

   task automatic test_reset_present;
      int n; bit ok;
      bus.char_ready = 1'b0;
      bus.seg_in = ~16'hCC42;
      wait_valid(40, n, ok);
      n_cmp++; if (ok !== 1'b1 || bus.char_out !== 7'h49) begin n_fail++; $display("FAIL rp_present got=%h ok=%b want=49", bus.char_out, ok); end
      reset = 1'b1;
      step(1);
      n_cmp++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL rp_valid got=%b want=0", bus.char_valid); end
      n_cmp++; if (bus.settled_pattern !== 16'h0000) begin n_fail++; $display("FAIL rp_settled got=%h want=0000", bus.settled_pattern); end
      step(1);
      reset = 1'b0;
      bus.char_ready = 1'b1;
      wait_valid(40, n, ok);
      n_cmp++; if (ok !== 1'b1 || bus.char_out !== 7'h49) begin n_fail++; $display("FAIL rp_fresh got=%h ok=%b want=49", bus.char_out, ok); end
      step(3);
   endtask

   task automatic test_random;
      logic [15:0] exp_settled;
      logic [15:0] p;
      logic [23:0] exp_q[$];
      logic [7:0]  d;
      int          nmin;
      exp_settled = 16'hCC42;
      bus.char_ready = 1'b1;
      mon_q.delete();
      mon_en = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            bus.seg_in = ~16'($urandom);
            step($urandom_range(1, 12));
         end
         if ($urandom_range(0, 3) == 0) p = 16'($urandom);
         else p = tbl_pat[$urandom_range(0, 8)];
         bus.seg_in = ~p;
         step($urandom_range(20, 30));
         if (p != exp_settled) begin
            d = ref_decode(p);
            exp_q.push_back({p, d});
            exp_settled = p;
         end
      end
      step(30);
      mon_en = 1'b0;
      n_cmp++; if (mon_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd_count got=%0d want=%0d", mon_q.size(), exp_q.size()); end
      nmin = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
      for (int i = 0; i < nmin; i++) begin
         n_cmp++;
         if (mon_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL rnd_char[%0d] got pat=%h unk=%b chr=%h want pat=%h unk=%b chr=%h", i,
                     mon_q[i][23:8], mon_q[i][7], mon_q[i][6:0], exp_q[i][23:8], exp_q[i][7], exp_q[i][6:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_hold();
      test_toggle();
      test_back_to_back();
      test_unknown();
      test_reset_present();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
